// File: rtl/ddr_model_pkg.sv
// Shared defaults and types for the behavioural DDR memory model.
package ddr_model_pkg;

  localparam int DDR_DATA_WIDTH = 32;
  localparam int DDR_DEPTH      = 1024;
  localparam int DDR_RD_LATENCY = 4;

  // One read-pipeline stage at the default word width: valid flag plus the word it carries.
  typedef struct packed {
    logic                      valid;
    logic [DDR_DATA_WIDTH-1:0] data;
  } rd_stage_t;

  // True when a word address falls inside a memory of the given depth.
  // Needed because DEPTH need not be a power of two.
  function automatic logic ddr_in_range(input int unsigned a, input int unsigned depth);
    return (a < depth) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/ddr_rd_pipe.sv
// RD_LATENCY-stage valid/data delay line for read returns.
// A stage only reloads its data when a valid word arrives, so the final
// stage keeps presenting the last returned word between pulses.
module ddr_rd_pipe
  import ddr_model_pkg::*;
#(
  parameter int DATA_WIDTH = DDR_DATA_WIDTH,
  parameter int RD_LATENCY = DDR_RD_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  stage_t stage_q [RD_LATENCY];
  stage_t stage_d [RD_LATENCY];

  // Next state: shift valid every cycle, move data only alongside a valid bit.
  always_comb begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      stage_d[i] = stage_q[i];
    end
    stage_d[0].valid = in_valid_i;
    if (in_valid_i) begin
      stage_d[0].data = in_data_i;
    end else begin
      stage_d[0].data = stage_q[0].data;
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      stage_d[i].valid = stage_q[i-1].valid;
      if (stage_q[i-1].valid) begin
        stage_d[i].data = stage_q[i-1].data;
      end else begin
        stage_d[i].data = stage_q[i].data;
      end
    end
  end

  // Stage registers; the async clear drops every in-flight read and zeroes the output word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid_o = stage_q[RD_LATENCY-1].valid;
  assign out_data_o  = stage_q[RD_LATENCY-1].data;

endmodule

// File: rtl/ddr_model.sv
// Behavioural single-port word memory with a fixed, fully pipelined read latency.
// Reads capture the array at the request edge (write-first on the shared
// address) and return through ddr_rd_pipe RD_LATENCY edges later.
module ddr_model
  import ddr_model_pkg::*;
#(
  parameter int DATA_WIDTH = DDR_DATA_WIDTH,
  parameter int DEPTH      = DDR_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = DDR_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  // Storage starts at zero and is deliberately never reset, so contents survive reset pulses.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic                  addr_ok_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] rd_word_d;

  assign addr_ok_s = ddr_in_range(32'(addr), 32'(DEPTH));
  // Writes while reset is held are ignored, as are writes beyond the last word.
  assign wr_en_s   = reset & wr_req & addr_ok_s;

  // Word captured by a read this edge: same-cycle write data wins, out-of-range reads give zero.
  always_comb begin
    rd_word_d = '0;
    if (!addr_ok_s) begin
      rd_word_d = '0;
    end else if (wr_req) begin
      rd_word_d = wr_data;
    end else begin
      rd_word_d = mem_q[addr];
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[addr] <= wr_data;
    end
  end

  ddr_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk_i       (clk),
    .rst_n_i     (reset),
    .in_valid_i  (rd_req),
    .in_data_i   (rd_word_d),
    .out_valid_o (rd_valid),
    .out_data_o  (rd_data)
  );

endmodule

// File: tb/tb_ddr_model.sv
// Self-checking bench for ddr_model: table of requests with expected read
// words, a scoreboard of (word, due edge), and a mid-read reset sequence.
module tb_ddr_model;
  import ddr_model_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int L     = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  ddr_model #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (L)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_stage_t     exp;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } sb_t;
  sb_t sb[$];

  logic [DW-1:0] last_exp = '0;

  function automatic void add(bit rd, bit wr, int a, logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = AW'(a); v.d = d;
    v.exp.valid = rd; v.exp.data = e;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs just after the falling edge; a read is due L-1 edges after the next edge.
  task automatic step(bit rst_v, bit rd, bit wr, int a, logic [31:0] d, logic [31:0] e);
    @(negedge clk);
    #1;
    reset   = rst_v;
    rd_req  = rd;
    wr_req  = wr;
    addr    = AW'(a);
    wr_data = d;
    if (!rst_v) sb.delete();
    else if (rd) sb.push_back('{data: e, due: edge_cnt + L});
  endtask

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_rd_valid", 32'(rd_valid), 32'd0);
      check("reset_rd_data", rd_data, 32'd0);
      last_exp = '0;
    end else if (rd_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got rd_valid=1 data %h, expected no pulse (edge %0d)", rd_data, edge_cnt);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_due_edge", 32'(edge_cnt), 32'(e.due));
        last_exp = e.data;
      end
    end else begin
      check("rd_data_hold", rd_data, last_exp);
      if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_valid: got rd_valid=0, expected data %h due edge %0d", sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;

    // rd, wr, addr, wdata, expected read word
    add(0, 1, 10, 32'hDEADBEEF, 32'h0);
    add(1, 0, 10, 32'h0, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) add(0, 1, i, 32'h1000 + 32'(i), 32'h0);
    for (int i = 0; i < 8; i++) add(1, 0, i, 32'h0, 32'h1000 + 32'(i));
    add(0, 1, 5, 32'h11111111, 32'h0);
    add(1, 1, 5, 32'hCAFEF00D, 32'hCAFEF00D);
    add(1, 0, 5, 32'h0, 32'hCAFEF00D);
    add(0, 1, 3, 32'hA5A5A5A5, 32'h0);
    add(1, 0, 3, 32'h0, 32'hA5A5A5A5);
    add(0, 1, 3, 32'h0, 32'h0);
    add(0, 0, 0, 32'h0, 32'h0);
    add(1, 0, 3, 32'h0, 32'h0);
    add(1, 0, 1023, 32'h0, 32'h0);
    add(1, 0, 900, 32'h0, 32'h0);
    add(0, 1, 1010, 32'h12345678, 32'h0);
    add(1, 0, 1010, 32'h0, 32'h0);
    add(1, 1, 1010, 32'h87654321, 32'h0);
    add(0, 1, 999, 32'h99999999, 32'h0);
    add(1, 0, 999, 32'h0, 32'h99999999);
    add(0, 0, 0, 32'h0, 32'h0);
    add(1, 0, 6, 32'h0, 32'h1006);

    repeat (3) step(0, 0, 0, 0, 32'h0, 32'h0);

    foreach (vecs[i]) step(1, vecs[i].rd, vecs[i].wr, int'(vecs[i].a), vecs[i].d, vecs[i].exp.data);
    repeat (L + 3) step(1, 0, 0, 0, 32'h0, 32'h0);

    // Read accepted, then reset held over the two edges before it is due.
    step(1, 1, 0, 10, 32'h0, 32'hDEADBEEF);
    step(1, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 1, 10, 32'hFFFFFFFF, 32'h0);
    // Release with a request in the same cycle: accepted at the first edge out of reset.
    step(1, 1, 0, 10, 32'h0, 32'hDEADBEEF);
    repeat (L + 3) step(1, 0, 0, 0, 32'h0, 32'h0);
    step(1, 1, 0, 7, 32'h0, 32'h1007);

    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1, 0, 0, 0, 32'h0, 32'h0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_model.md
DDR_MODEL -- requirements
Module: ddr_model

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each memory word and of wr_data/rd_data.
REQ-002 Parameter DEPTH, default 1024: number of words.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), i.e. 10: address width.
REQ-004 Parameter RD_LATENCY, default 4, legal range 1..16: clock edges from read acceptance to rd_valid.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset (asserted at 0).
REQ-007 Port rd_req, input, 1: read request, sampled every rising edge.
REQ-008 Port wr_req, input, 1: write request, sampled every rising edge.
REQ-009 Port addr, input, ADDR_WIDTH: shared word address for reads and writes.
REQ-010 Port wr_data, input, DATA_WIDTH: write data.
REQ-011 Port rd_data, output, DATA_WIDTH: read data, meaningful when rd_valid=1.
REQ-012 Port rd_valid, output, 1: one-cycle pulse per completed read.

Function
REQ-013 No ready/backpressure; every request sampled while reset is deasserted is accepted.
REQ-014 Write: wr_req=1 at edge N stores wr_data into mem[addr] at edge N.
REQ-015 Read: rd_req=1 at edge N captures mem[addr] at edge N; rd_valid=1 and rd_data=captured word for exactly one cycle after edge N+RD_LATENCY-1 (visible from edge N+RD_LATENCY-1 to edge N+RD_LATENCY).
REQ-016 Reads are fully pipelined: rd_req on consecutive cycles yields rd_valid on consecutive cycles, in request order, no loss.
REQ-017 Simultaneous rd_req and wr_req, same address: write-first; read returns the new wr_data.
REQ-018 Simultaneous rd_req and wr_req, different addresses: both performed.
REQ-019 Write to an address after its read was accepted does not alter that read's returned data.
REQ-020 Address >= DEPTH (non-power-of-two DEPTH): write ignored; read returns all zeros with normal rd_valid timing.
REQ-021 rd_data holds its last returned value while rd_valid=0.
REQ-022 Memory contents initialise to all zeros at time zero (simulation model; no reset of array).

Reset
REQ-023 While reset=0: rd_valid=0, rd_data=0, all in-flight reads discarded, requests ignored.
REQ-024 Reset asserted mid-read cancels the read; no rd_valid is produced for it after release.
REQ-025 Memory contents are preserved across reset.
REQ-026 First request is accepted at the first rising edge with reset=1.

Structure
REQ-027 Package ddr_model_pkg holds default constants (DDR_DATA_WIDTH=32, DDR_DEPTH=1024, DDR_RD_LATENCY=4) and a struct typedef for one read-pipeline stage (valid bit + data word).
REQ-028 One sub-module ddr_rd_pipe: parameterised RD_LATENCY-stage valid/data delay line with async active-low clear; ddr_model contains the array, write logic and read capture.

Verification
REQ-029 Write addr=10 data=0xDEADBEEF, then read addr=10 -> one rd_valid pulse RD_LATENCY edges after acceptance, rd_data=0xDEADBEEF.
REQ-030 Write addr 0..7 with 0x1000+i, then 8 back-to-back reads -> 8 consecutive rd_valid cycles returning 0x1000..0x1007 in order.
REQ-031 Same-cycle rd_req+wr_req addr=5 data=0xCAFEF00D (old 0x11111111) -> read returns 0xCAFEF00D.
REQ-032 Read addr=3 (holds 0xA5A5A5A5), write addr=3 0x0 next cycle -> read returns 0xA5A5A5A5.
REQ-033 Read accepted, reset pulsed low 2 cycles before due -> no rd_valid, rd_data=0; earlier-written 0xDEADBEEF at addr 10 still readable after release.
REQ-034 Read never-written addr=1023 -> rd_valid pulse with rd_data=0x00000000.
